// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg: shared FP16 width, feeder state encoding and FP16 constants.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package systolic_pkg;

  localparam int FP16_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOADW0 = 3'd1,
    LOADW1 = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_TWO  = 16'h4000;
  localparam logic [FP16_W-1:0] FP16_FOUR = 16'h4400;
  localparam logic [FP16_W-1:0] FP16_FIVE = 16'h4500;

  // Lane idx of a packed 4-element FP16 vector, lane 0 in the low bits.
  function automatic logic [FP16_W-1:0] fp16_lane(input logic [4*FP16_W-1:0] v,
                                                  input int unsigned idx);
    return v[idx*FP16_W +: FP16_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_feeder_if.sv
// ---------------------------------------------------------------------------
// systolic_feeder_if: weight-set and activation-row valid/ready channels.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface systolic_feeder_if;
  import systolic_pkg::*;

  logic [4*FP16_W-1:0] w_data;
  logic                w_valid;
  logic                w_ready;
  logic [2*FP16_W-1:0] a_data;
  logic                a_valid;
  logic                a_last;
  logic                a_ready;

  modport master (
    output w_data, w_valid, a_data, a_valid, a_last,
    input  w_ready, a_ready
  );

  modport slave (
    input  w_data, w_valid, a_data, a_valid, a_last,
    output w_ready, a_ready
  );

endinterface

`default_nettype wire

// File: rtl/systolic_skew_reg.sv
// ---------------------------------------------------------------------------
// systolic_skew_reg: one-deep delay line that loads zero whenever load is low.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module systolic_skew_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      q <= load ? d : '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder: weight loader and skewed activation streamer for the 2x2
// FP16 systolic array. Optional stall counter: FEEDER_STALL_CNT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  systolic_feeder_if.slave  bus,
  output logic [FP16_W-1:0] top1,
  output logic [FP16_W-1:0] top2,
  output logic [FP16_W-1:0] left1,
  output logic [FP16_W-1:0] left2,
  output logic              we1,
  output logic              we2,
  output logic              we3,
  output logic              we4,
  output logic              mux1,
  output logic              mux2,
  output logic              mux3,
  output logic              mux4,
  output logic              row_valid,
  output logic              busy,
`ifdef FEEDER_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              done
);

  localparam int W     = FP16_W;
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t           state, state_nxt;
  logic [2*W-1:0]   w_hold, w_hold_nxt;
  logic [CNT_W-1:0] drain_cnt, drain_cnt_nxt;
  logic [W-1:0]     top1_nxt, top2_nxt, left1_nxt, left2_nxt;
  logic [3:0]       we_q, we_nxt;
  logic             mux_q, mux_nxt;
  logic             row_valid_nxt, busy_nxt, done_nxt;
  logic             a_acc;
  logic [W-1:0]     skew;

  assign bus.w_ready = (state == IDLE);
  assign bus.a_ready = (state == STREAM);
  assign a_acc       = bus.a_valid && (state == STREAM);

  assign {we4, we3, we2, we1}     = we_q;
  assign {mux4, mux3, mux2, mux1} = {4{mux_q}};

  // Holds A1 of the accepted row for one cycle so row 1 lags row 0.
  systolic_skew_reg #(.WIDTH(W)) u_skew (
    .clk   (clk),
    .reset (reset),
    .load  (a_acc),
    .d     (bus.a_data[2*W-1:W]),
    .q     (skew)
  );

  // Next values describe the pins for the state being entered.
  always_comb begin
    state_nxt     = state;
    w_hold_nxt    = w_hold;
    drain_cnt_nxt = drain_cnt;
    top1_nxt      = FP16_ZERO;
    top2_nxt      = FP16_ZERO;
    left1_nxt     = FP16_ZERO;
    left2_nxt     = FP16_ZERO;
    we_nxt        = 4'b0000;
    mux_nxt       = 1'b0;
    row_valid_nxt = 1'b0;
    done_nxt      = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.w_valid) begin
          state_nxt  = LOADW0;
          w_hold_nxt = bus.w_data[2*W-1:0];
          top1_nxt   = fp16_lane(bus.w_data, 2);
          top2_nxt   = fp16_lane(bus.w_data, 3);
          we_nxt     = 4'b0101;
        end
      end
      LOADW0: begin
        state_nxt = LOADW1;
        top1_nxt  = w_hold[W-1:0];
        top2_nxt  = w_hold[2*W-1:W];
        we_nxt    = 4'b1010;
      end
      LOADW1: begin
        state_nxt = STREAM;
        mux_nxt   = 1'b1;
      end
      STREAM: begin
        mux_nxt       = 1'b1;
        left1_nxt     = a_acc ? bus.a_data[W-1:0] : FP16_ZERO;
        left2_nxt     = skew;
        row_valid_nxt = a_acc;
        if (a_acc && bus.a_last) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = '0;
        end
      end
      DRAIN: begin
        if (drain_cnt == CNT_LAST) begin
          state_nxt     = IDLE;
          done_nxt      = 1'b1;
          drain_cnt_nxt = '0;
        end else begin
          mux_nxt       = 1'b1;
          left2_nxt     = skew;
          drain_cnt_nxt = drain_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      w_hold    <= '0;
      drain_cnt <= '0;
      top1      <= FP16_ZERO;
      top2      <= FP16_ZERO;
      left1     <= FP16_ZERO;
      left2     <= FP16_ZERO;
      we_q      <= 4'b0000;
      mux_q     <= 1'b0;
      row_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      w_hold    <= w_hold_nxt;
      drain_cnt <= drain_cnt_nxt;
      top1      <= top1_nxt;
      top2      <= top2_nxt;
      left1     <= left1_nxt;
      left2     <= left2_nxt;
      we_q      <= we_nxt;
      mux_q     <= mux_nxt;
      row_valid <= row_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

`ifdef FEEDER_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'h0000;
    end else if ((state == IDLE) && bus.w_valid) begin
      stall_cnt <= 16'h0000;
    end else if ((state == STREAM) && !bus.a_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_feeder: scoreboard bench for systolic_feeder pin sequences.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_systolic_feeder;
  import systolic_pkg::*;

  localparam int DC = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  systolic_feeder_if bus();

  logic [15:0] top1, top2, left1, left2;
  logic        we1, we2, we3, we4, mux1, mux2, mux3, mux4;
  logic        row_valid, busy, done;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  systolic_feeder #(.DRAIN_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .top1      (top1),
    .top2      (top2),
    .left1     (left1),
    .left2     (left2),
    .we1       (we1),
    .we2       (we2),
    .we3       (we3),
    .we4       (we4),
    .mux1      (mux1),
    .mux2      (mux2),
    .mux3      (mux3),
    .mux4      (mux4),
    .row_valid (row_valid),
    .busy      (busy),
`ifdef FEEDER_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .done      (done)
  );

  typedef struct {
    string       tag;
    logic [79:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Packing: {pad, top1, top2, left1, left2, we4..we1, mux4..mux1, row_valid, busy, done, w_ready, a_ready}
  function automatic logic [79:0] ev(input logic [15:0] t1, t2, l1, l2, input logic [3:0] we,
                                     input logic mx, rv, bz, dn, wr, ar);
    return {3'b000, t1, t2, l1, l2, we, {4{mx}}, rv, bz, dn, wr, ar};
  endfunction

  function automatic logic [79:0] obs();
    return {3'b000, top1, top2, left1, left2, we4, we3, we2, we1, mux4, mux3, mux2, mux1,
            row_valid, busy, done, bus.w_ready, bus.a_ready};
  endfunction

  function automatic logic [79:0] idle_v(input logic dn);
    return ev(16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 1'b0, 1'b0, 1'b0, dn, 1'b1, 1'b0);
  endfunction

  // Stream/drain pins: computing mode, no weight traffic, busy.
  function automatic logic [79:0] sv(input logic [15:0] l1, l2, input logic rv, ar);
    return ev(16'h0, 16'h0, l1, l2, 4'b0000, 1'b1, rv, 1'b1, 1'b0, 1'b0, ar);
  endfunction

  task automatic step(input string tag, input logic wv, input logic [63:0] wd,
                      input logic av, input logic [31:0] ad, input logic al,
                      input logic [79:0] e);
    exp_t it;
    bus.w_valid = wv;
    bus.w_data  = wd;
    bus.a_valid = av;
    bus.a_data  = ad;
    bus.a_last  = al;
    it.tag = tag;
    it.v   = e;
    sb.push_back(it);
    @(posedge clk);
    #1;
    it = sb.pop_front();
    chk(it.tag, obs(), it.v);
  endtask

  task automatic load(input logic [63:0] wd);
    step("loadw0", 1'b1, wd, 1'b0, 32'h0, 1'b0,
         ev(wd[47:32], wd[63:48], 16'h0, 16'h0, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    step("loadw1", 1'b0, 64'h0, 1'b1, 32'hABCD_1234, 1'b1,
         ev(wd[15:0], wd[31:16], 16'h0, 16'h0, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    step("stream_entry", 1'b0, 64'h0, 1'b0, 32'h0, 1'b0, sv(16'h0, 16'h0, 1'b0, 1'b1));
  endtask

  task automatic drain(input logic [15:0] a1, input logic junk);
    step("drain_a1", junk, 64'hFFFF_FFFF_FFFF_FFFF, junk, 32'hDEAD_BEEF, junk,
         sv(16'h0, a1, 1'b0, 1'b0));
    for (int i = 1; i < DC - 1; i++) begin
      step("drain_zero", junk, 64'hFFFF_FFFF_FFFF_FFFF, junk, 32'hDEAD_BEEF, junk,
           sv(16'h0, 16'h0, 1'b0, 1'b0));
    end
    step("done_pulse", junk, 64'hFFFF_FFFF_FFFF_FFFF, junk, 32'hDEAD_BEEF, junk, idle_v(1'b1));
    step("idle_after", 1'b0, 64'h0, junk, 32'hDEAD_BEEF, 1'b0, idle_v(1'b0));
  endtask

  initial begin
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
    bus.a_valid = 1'b0;
    bus.a_data  = '0;
    bus.a_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", obs(), idle_v(1'b0));
    reset = 1'b1;
    step("idle", 1'b0, 64'h0, 1'b1, 32'h1111_2222, 1'b1, idle_v(1'b0));

    // Test-plan job: W00=5.0, rows (4.0,2.0) then last (0xD640,0x56E0).
    load({48'h0, FP16_FIVE});
    step("a_row0", 1'b0, 64'h0, 1'b1, {FP16_TWO, FP16_FOUR}, 1'b0,
         sv(FP16_FOUR, 16'h0, 1'b1, 1'b1));
    step("a_last", 1'b0, 64'h0, 1'b1, {16'h56E0, 16'hD640}, 1'b1,
         sv(16'hD640, FP16_TWO, 1'b1, 1'b0));
    drain(16'h56E0, 1'b0);

    // Bubbles mid-stream, w_valid held high throughout (must be ignored).
    load({16'h4400, 16'h4000, 16'h4500, 16'h3C00});
    step("b_row0", 1'b1, 64'h1, 1'b1, 32'h1111_2222, 1'b0, sv(16'h2222, 16'h0, 1'b1, 1'b1));
    step("b_bub0", 1'b1, 64'h1, 1'b0, 32'hFFFF_FFFF, 1'b1, sv(16'h0, 16'h1111, 1'b0, 1'b1));
    step("b_bub1", 1'b1, 64'h1, 1'b0, 32'hFFFF_FFFF, 1'b1, sv(16'h0, 16'h0, 1'b0, 1'b1));
    step("b_row1", 1'b1, 64'h1, 1'b1, 32'h3333_4444, 1'b0, sv(16'h4444, 16'h0, 1'b1, 1'b1));
    step("b_last", 1'b1, 64'h1, 1'b1, 32'h5555_6666, 1'b1, sv(16'h6666, 16'h3333, 1'b1, 1'b0));
    drain(16'h5555, 1'b1);
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_b", {64'h0, stall_cnt}, 80'd2);
`endif

    // Five bubbles then a single-row job.
    load({16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD});
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_clear", {64'h0, stall_cnt}, 80'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      step("c_bubble", 1'b0, 64'h0, 1'b0, 32'hFFFF_FFFF, 1'b1, sv(16'h0, 16'h0, 1'b0, 1'b1));
    end
    step("c_single", 1'b0, 64'h0, 1'b1, 32'h7E00_FC00, 1'b1, sv(16'hFC00, 16'h0, 1'b1, 1'b0));
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_five", {64'h0, stall_cnt}, 80'd5);
`endif
    drain(16'h7E00, 1'b0);

    // Asynchronous reset in the middle of a stream.
    load({16'h0001, 16'h0002, 16'h0003, 16'h0004});
    step("d_row0", 1'b0, 64'h0, 1'b1, 32'h1234_5678, 1'b0, sv(16'h5678, 16'h0, 1'b1, 1'b1));
    reset = 1'b0;
    #2;
    chk("async_reset", obs(), idle_v(1'b0));
    @(posedge clk);
    #1;
    chk("reset_hold", obs(), idle_v(1'b0));
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("post_reset", 1'b0, 64'h0, 1'b0, 32'h0, 1'b0, idle_v(1'b0));
    end
    load({16'h3800, 16'h3C00, 16'hC000, 16'h4200});
    step("e_single", 1'b0, 64'h0, 1'b1, 32'h4900_4A00, 1'b1, sv(16'h4A00, 16'h0, 1'b1, 1'b0));
    drain(16'h4900, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
